cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Microcoded control sequencer for the 2600 CPU core. Each cycle it drives the gate, load and increment strobes that steer the ADH/ADL address buses and the internal DataBus. It runs the reset-vector fetch, opcode fetch and a minimal instruction subset with 6502-accurate cycle counts. It contains no datapath registers: it reads the instruction register and drives strobes that the datapath obeys on the same clock edge.

## Interface
Parameters:
- none (opcode encodings and vector addresses are fixed constants in the package)

Ports:
- Clk  input  1  system clock; all state changes on rising edge
- Reset_n  input  1  synchronous, active-low reset
- Rdy  input  1  0 = stall the current read cycle (TIA WSYNC); ignored on write cycles
- IR  input  8  current instruction register contents from datapath
- R  output  1  1 = read, 0 = write
- Sync  output  1  1 during the opcode-fetch cycle
- Halt  output  1  1 after an unsupported opcode
- Gate_ADH_PCH, Gate_ADH_TmpH, Gate_ADH_Zero, Gate_ADH_Reset  output  1 each  ADH source (exactly one high); Reset drives 8'hFF
- Gate_ADL_PCL, Gate_ADL_TmpL, Gate_ADL_Reset_0, Gate_ADL_Reset_1  output  1 each  ADL source (exactly one high); Reset_0 drives 8'hFC, Reset_1 drives 8'hFD
- Gate_DataBus_A  output  1  drive A onto external Data (store)
- LD_IR, LD_TmpL, LD_TmpH, LD_A, LD_X, LD_PC  output  1 each  load from Data; LD_PC loads PC ← {Data, TmpL}
- PC_Inc, INC_X  output  1 each  PC += 1; X += 1 (8-bit wrap)

## Operation
States:
- RST_0
- RST_1
- FETCH
- OPER
- ZP_MEM
- ABS_HI
- ABS_MEM
- HALT

Per-state behaviour; unlisted strobes are 0:
- RST_0: ADH=Reset, ADL=Reset_0, R=1, LD_TmpL → RST_1.
- RST_1: ADH=Reset, ADL=Reset_1, R=1, LD_PC → FETCH.
- FETCH: ADH=PCH, ADL=PCL, R=1, Sync=1, LD_IR, PC_Inc → OPER.
- OPER: address=PC, R=1; transition depends on IR:
  - A9 LDA#: LD_A, PC_Inc → FETCH.
  - A2 LDX#: LD_X, PC_Inc → FETCH.
  - E8 INX: INC_X → FETCH.
  - EA NOP: → FETCH.
  - A5 LDA zp, 85 STA zp: LD_TmpL, PC_Inc → ZP_MEM.
  - AD LDA abs, 8D STA abs, 4C JMP abs: LD_TmpL, PC_Inc → ABS_HI.
  - any other value: no strobes → HALT.
- ZP_MEM: ADH=Zero, ADL=TmpL. For LDA: R=1, LD_A. For STA: R=0, Gate_DataBus_A. → FETCH.
- ABS_HI: address=PC, R=1, PC_Inc. For JMP: LD_PC → FETCH (PC_Inc is suppressed for JMP). Otherwise: LD_TmpH → ABS_MEM.
- ABS_MEM: ADH=TmpH, ADL=TmpL. Load/store as in ZP_MEM → FETCH.
- HALT: address=PC, R=1, Halt=1, no strobes; remains in HALT until reset.

Cycle counts, FETCH to FETCH inclusive:
- 2 cycles: LDA#, LDX#, INX, NOP
- 3 cycles: zp ops, JMP
- 4 cycles: abs ops

## Timing
- Outputs are combinational decodes of the registered state and IR. Strobes take effect at the rising edge that ends the cycle.
- Reset_n=0 at an edge sets state to RST_0.
- While Reset_n=0, outputs are:
  - R=1
  - Sync=0, Halt=0
  - Gate_ADH_Reset=1, Gate_ADL_Reset_0=1
  - all LD_*, PC_Inc, INC_X and Gate_DataBus_A forced to 0
- First FETCH occurs 2 cycles after Reset_n rises.
- Reset mid-instruction (including during a write or in HALT) abandons the instruction with no further strobes.
- Rdy=0 in a cycle with R=1:
  - state holds;
  - all LD_*, PC_Inc and INC_X are forced to 0;
  - address gates, R and Sync hold their values.
- Rdy is ignored in write cycles (R=0) and in HALT.
- Rdy toggling every cycle stretches each read by the number of low cycles; there is no lost or duplicated strobe.
- Gate mutual exclusion: at most one ADH gate and one ADL gate are high in any cycle. The bench checks this every cycle.

## Structure
- cpu_pkg holds the shared constants and is also used by the datapath:
  - state_t enum
  - opcode localparams (OP_LDA_IMM=8'hA9, etc.)
  - vector constants 8'hFF, 8'hFC, 8'hFD
  - op_class_t enum: IMM, IMPL, ZP, ABS, JMP, ILLEGAL
- Sub-module cpu_opdecode is combinational. It maps IR to op_class_t and flags is_store, ld_a, ld_x, inc_x.
- cpu_sequencer holds only the state register and the strobe decode.

## Test plan
- Reset_n low 3 cycles, then high. Required response:
  - RST_0 with FFFC read, then RST_1 with FFFD read and LD_PC;
  - Sync=1 on the 3rd cycle after release.
- IR=A9 sequence: FETCH, then OPER with LD_A and PC_Inc, then FETCH; Sync high exactly every 2nd cycle.
- STA abs (8D):
  - 4 cycles;
  - ABS_MEM has R=0, Gate_DataBus_A=1, Gate_ADH_TmpH=1, Gate_ADL_TmpL=1;
  - PC_Inc asserted exactly 3 times.
- JMP abs (4C): 3 cycles; LD_PC in ABS_HI with PC_Inc=0; next cycle is FETCH.
- LDA zp (A5) with Rdy=0 for 5 cycles during ZP_MEM:
  - state held 5 extra cycles;
  - LD_A asserted only on the cycle where Rdy=1.
- IR=02 (illegal):
  - HALT entered after OPER and Halt=1 persists for 100 cycles with no strobes;
  - Reset_n pulse returns to RST_0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 2600 CPU core: sequencer state codes, opcodes,
// reset vector bytes and the instruction classes produced by the decoder.
package cpu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RST_0   = 3'd0;
    localparam state_t ST_RST_1   = 3'd1;
    localparam state_t ST_FETCH   = 3'd2;
    localparam state_t ST_OPER    = 3'd3;
    localparam state_t ST_ZP_MEM  = 3'd4;
    localparam state_t ST_ABS_HI  = 3'd5;
    localparam state_t ST_ABS_MEM = 3'd6;
    localparam state_t ST_HALT    = 3'd7;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
    localparam logic [7:0] OP_STA_ZP  = 8'h85;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    localparam logic [7:0] VEC_RESET_HI   = 8'hFF;
    localparam logic [7:0] VEC_RESET_LO_0 = 8'hFC;
    localparam logic [7:0] VEC_RESET_LO_1 = 8'hFD;

    typedef enum logic [2:0] {
        IMM,
        IMPL,
        ZP,
        ABS,
        JMP,
        ILLEGAL
    } op_class_t;

endpackage

// File: rtl/cpu_opdecode.sv
// Combinational opcode classifier: maps the instruction register to an
// addressing class plus the per-opcode data flags used by the sequencer.
module cpu_opdecode
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output op_class_t  op_class,
    output logic       is_store,
    output logic       ld_a,
    output logic       ld_x,
    output logic       inc_x
);

    always_comb begin
        op_class = ILLEGAL;
        is_store = 1'b0;
        ld_a     = 1'b0;
        ld_x     = 1'b0;
        inc_x    = 1'b0;
        case (ir)
            OP_LDA_IMM: begin op_class = IMM;  ld_a     = 1'b1; end
            OP_LDX_IMM: begin op_class = IMM;  ld_x     = 1'b1; end
            OP_INX:     begin op_class = IMPL; inc_x    = 1'b1; end
            OP_NOP:     begin op_class = IMPL;                  end
            OP_LDA_ZP:  begin op_class = ZP;   ld_a     = 1'b1; end
            OP_STA_ZP:  begin op_class = ZP;   is_store = 1'b1; end
            OP_LDA_ABS: begin op_class = ABS;  ld_a     = 1'b1; end
            OP_STA_ABS: begin op_class = ABS;  is_store = 1'b1; end
            OP_JMP_ABS: begin op_class = JMP;                   end
            default:    begin op_class = ILLEGAL;               end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer: state register plus decode of the bus gate, load and
// increment strobes for the reset vector fetch and the supported opcodes.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Rdy,
    input  logic [7:0] IR,
    output logic       R,
    output logic       Sync,
    output logic       Halt,
    output logic       Gate_ADH_PCH,
    output logic       Gate_ADH_TmpH,
    output logic       Gate_ADH_Zero,
    output logic       Gate_ADH_Reset,
    output logic       Gate_ADL_PCL,
    output logic       Gate_ADL_TmpL,
    output logic       Gate_ADL_Reset_0,
    output logic       Gate_ADL_Reset_1,
    output logic       Gate_DataBus_A,
    output logic       LD_IR,
    output logic       LD_TmpL,
    output logic       LD_TmpH,
    output logic       LD_A,
    output logic       LD_X,
    output logic       LD_PC,
    output logic       PC_Inc,
    output logic       INC_X
);

    state_t    state_q, state_d, state_next;
    op_class_t op_class;
    logic      is_store, dec_ld_a, dec_ld_x, dec_inc_x;

    logic r_raw, sync_raw, halt_raw, gate_db_raw;
    logic adh_pch, adh_tmph, adh_zero, adh_rst;
    logic adl_pcl, adl_tmpl, adl_rst0, adl_rst1;
    logic ld_ir_raw, ld_tmpl_raw, ld_tmph_raw, ld_a_raw, ld_x_raw, ld_pc_raw;
    logic pc_inc_raw, inc_x_raw;
    logic stall, strobe_en;

    cpu_opdecode u_opdecode (
        .ir       (IR),
        .op_class (op_class),
        .is_store (is_store),
        .ld_a     (dec_ld_a),
        .ld_x     (dec_ld_x),
        .inc_x    (dec_inc_x)
    );

    always_comb begin
        state_next  = state_q;
        r_raw       = 1'b1;
        sync_raw    = 1'b0;
        halt_raw    = 1'b0;
        gate_db_raw = 1'b0;
        adh_pch     = 1'b0;
        adh_tmph    = 1'b0;
        adh_zero    = 1'b0;
        adh_rst     = 1'b0;
        adl_pcl     = 1'b0;
        adl_tmpl    = 1'b0;
        adl_rst0    = 1'b0;
        adl_rst1    = 1'b0;
        ld_ir_raw   = 1'b0;
        ld_tmpl_raw = 1'b0;
        ld_tmph_raw = 1'b0;
        ld_a_raw    = 1'b0;
        ld_x_raw    = 1'b0;
        ld_pc_raw   = 1'b0;
        pc_inc_raw  = 1'b0;
        inc_x_raw   = 1'b0;
        case (state_q)
            ST_RST_0: begin
                adh_rst     = 1'b1;
                adl_rst0    = 1'b1;
                ld_tmpl_raw = 1'b1;
                state_next  = ST_RST_1;
            end
            ST_RST_1: begin
                adh_rst    = 1'b1;
                adl_rst1   = 1'b1;
                ld_pc_raw  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                adh_pch    = 1'b1;
                adl_pcl    = 1'b1;
                sync_raw   = 1'b1;
                ld_ir_raw  = 1'b1;
                pc_inc_raw = 1'b1;
                state_next = ST_OPER;
            end
            ST_OPER: begin
                adh_pch = 1'b1;
                adl_pcl = 1'b1;
                case (op_class)
                    IMM: begin
                        ld_a_raw   = dec_ld_a;
                        ld_x_raw   = dec_ld_x;
                        pc_inc_raw = 1'b1;
                        state_next = ST_FETCH;
                    end
                    IMPL: begin
                        inc_x_raw  = dec_inc_x;
                        state_next = ST_FETCH;
                    end
                    ZP: begin
                        ld_tmpl_raw = 1'b1;
                        pc_inc_raw  = 1'b1;
                        state_next  = ST_ZP_MEM;
                    end
                    ABS, JMP: begin
                        ld_tmpl_raw = 1'b1;
                        pc_inc_raw  = 1'b1;
                        state_next  = ST_ABS_HI;
                    end
                    default: state_next = ST_HALT;
                endcase
            end
            ST_ZP_MEM, ST_ABS_MEM: begin
                adh_zero    = (state_q == ST_ZP_MEM);
                adh_tmph    = (state_q == ST_ABS_MEM);
                adl_tmpl    = 1'b1;
                r_raw       = !is_store;
                gate_db_raw = is_store;
                ld_a_raw    = dec_ld_a;
                state_next  = ST_FETCH;
            end
            ST_ABS_HI: begin
                adh_pch = 1'b1;
                adl_pcl = 1'b1;
                if (op_class == JMP) begin
                    ld_pc_raw  = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    ld_tmph_raw = 1'b1;
                    pc_inc_raw  = 1'b1;
                    state_next  = ST_ABS_MEM;
                end
            end
            default: begin
                adh_pch  = 1'b1;
                adl_pcl  = 1'b1;
                halt_raw = 1'b1;
            end
        endcase
    end

    // A low Rdy only stretches read cycles; writes and reset always proceed.
    assign stall     = !Rdy && r_raw;
    assign strobe_en = Reset_n && !stall;

    always_comb begin
        state_d = state_next;
        if (stall) begin
            state_d = state_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_RST_0;
        end else begin
            state_q <= state_d;
        end
    end

    // While Reset_n is low the bus points at the reset vector and nothing loads.
    assign R                = !Reset_n || r_raw;
    assign Sync             = Reset_n && sync_raw;
    assign Halt             = Reset_n && halt_raw;
    assign Gate_ADH_PCH     = Reset_n && adh_pch;
    assign Gate_ADH_TmpH    = Reset_n && adh_tmph;
    assign Gate_ADH_Zero    = Reset_n && adh_zero;
    assign Gate_ADH_Reset   = !Reset_n || adh_rst;
    assign Gate_ADL_PCL     = Reset_n && adl_pcl;
    assign Gate_ADL_TmpL    = Reset_n && adl_tmpl;
    assign Gate_ADL_Reset_0 = !Reset_n || adl_rst0;
    assign Gate_ADL_Reset_1 = Reset_n && adl_rst1;
    assign Gate_DataBus_A   = Reset_n && gate_db_raw;
    assign LD_IR            = strobe_en && ld_ir_raw;
    assign LD_TmpL          = strobe_en && ld_tmpl_raw;
    assign LD_TmpH          = strobe_en && ld_tmph_raw;
    assign LD_A             = strobe_en && ld_a_raw;
    assign LD_X             = strobe_en && ld_x_raw;
    assign LD_PC            = strobe_en && ld_pc_raw;
    assign PC_Inc           = strobe_en && pc_inc_raw;
    assign INC_X            = strobe_en && inc_x_raw;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a per-opcode cycle-script model predicts every
// output each cycle under random opcodes, Rdy stalls and resets.
module tb_cpu_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Rdy = 1'b1;
    logic [7:0] IR = 8'h00;
    logic R, Sync, Halt;
    logic Gate_ADH_PCH, Gate_ADH_TmpH, Gate_ADH_Zero, Gate_ADH_Reset;
    logic Gate_ADL_PCL, Gate_ADL_TmpL, Gate_ADL_Reset_0, Gate_ADL_Reset_1;
    logic Gate_DataBus_A, LD_IR, LD_TmpL, LD_TmpH, LD_A, LD_X, LD_PC, PC_Inc, INC_X;

    cpu_sequencer dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Rdy              (Rdy),
        .IR               (IR),
        .R                (R),
        .Sync             (Sync),
        .Halt             (Halt),
        .Gate_ADH_PCH     (Gate_ADH_PCH),
        .Gate_ADH_TmpH    (Gate_ADH_TmpH),
        .Gate_ADH_Zero    (Gate_ADH_Zero),
        .Gate_ADH_Reset   (Gate_ADH_Reset),
        .Gate_ADL_PCL     (Gate_ADL_PCL),
        .Gate_ADL_TmpL    (Gate_ADL_TmpL),
        .Gate_ADL_Reset_0 (Gate_ADL_Reset_0),
        .Gate_ADL_Reset_1 (Gate_ADL_Reset_1),
        .Gate_DataBus_A   (Gate_DataBus_A),
        .LD_IR            (LD_IR),
        .LD_TmpL          (LD_TmpL),
        .LD_TmpH          (LD_TmpH),
        .LD_A             (LD_A),
        .LD_X             (LD_X),
        .LD_PC            (LD_PC),
        .PC_Inc           (PC_Inc),
        .INC_X            (INC_X)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       r;
        logic       sync;
        logic       halt;
        logic [3:0] adh;   // {PCH, TmpH, Zero, Reset}
        logic [3:0] adl;   // {PCL, TmpL, Reset_0, Reset_1}
        logic       gdb;
        logic [7:0] st;    // {IR, TmpL, TmpH, A, X, PC, PC_Inc, INC_X}
    } exp_t;

    localparam logic [3:0] A_PC = 4'b1000, A_TMP = 4'b0100, A_ZERO = 4'b0010;
    localparam logic [3:0] A_RST = 4'b0001, A_R0 = 4'b0010, A_R1 = 4'b0001;
    localparam logic [7:0] S_IR = 8'h80, S_TMPL = 8'h40, S_TMPH = 8'h20, S_A = 8'h10;
    localparam logic [7:0] S_X = 8'h08, S_PC = 8'h04, S_INC = 8'h02, S_INX = 8'h01;

    exp_t act;
    assign act = {R, Sync, Halt, Gate_ADH_PCH, Gate_ADH_TmpH, Gate_ADH_Zero, Gate_ADH_Reset,
                  Gate_ADL_PCL, Gate_ADL_TmpL, Gate_ADL_Reset_0, Gate_ADL_Reset_1,
                  Gate_DataBus_A, LD_IR, LD_TmpL, LD_TmpH, LD_A, LD_X, LD_PC, PC_Inc, INC_X};

    exp_t       q[$];
    logic [7:0] prog[$];
    logic [7:0] pend_op;
    bit         halt_pend = 1'b0;
    int         stall_left = 0;
    int         cmp_cnt = 0;
    int         err_cnt = 0;

    function automatic exp_t rd(logic [3:0] adh, logic [3:0] adl, logic [7:0] st);
        exp_t e = '0;
        e.r = 1'b1; e.adh = adh; e.adl = adl; e.st = st;
        return e;
    endfunction

    function automatic exp_t wr(logic [3:0] adh, logic [3:0] adl);
        exp_t e = '0;
        e.adh = adh; e.adl = adl; e.gdb = 1'b1;
        return e;
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pick the next opcode and queue its whole FETCH..last cycle script.
    task automatic refill();
        logic [7:0] legal[9] = '{8'hA9, 8'hA2, 8'hE8, 8'hEA, 8'hA5, 8'h85, 8'hAD, 8'h8D, 8'h4C};
        logic [7:0] bad[4] = '{8'h02, 8'h00, 8'hFF, 8'h6C};
        exp_t f;
        if (prog.size() > 0) pend_op = prog.pop_front();
        else if ($urandom_range(0, 39) == 0) pend_op = bad[$urandom_range(0, 3)];
        else pend_op = legal[$urandom_range(0, 8)];
        f = rd(A_PC, A_PC, S_IR | S_INC);
        f.sync = 1'b1;
        q.push_back(f);
        case (pend_op)
            8'hA9: q.push_back(rd(A_PC, A_PC, S_A | S_INC));
            8'hA2: q.push_back(rd(A_PC, A_PC, S_X | S_INC));
            8'hE8: q.push_back(rd(A_PC, A_PC, S_INX));
            8'hEA: q.push_back(rd(A_PC, A_PC, 8'h00));
            8'hA5: begin
                q.push_back(rd(A_PC, A_PC, S_TMPL | S_INC));
                q.push_back(rd(A_ZERO, A_TMP, S_A));
            end
            8'h85: begin
                q.push_back(rd(A_PC, A_PC, S_TMPL | S_INC));
                q.push_back(wr(A_ZERO, A_TMP));
            end
            8'hAD, 8'h8D: begin
                q.push_back(rd(A_PC, A_PC, S_TMPL | S_INC));
                q.push_back(rd(A_PC, A_PC, S_TMPH | S_INC));
                if (pend_op == 8'hAD) q.push_back(rd(A_TMP, A_TMP, S_A));
                else q.push_back(wr(A_TMP, A_TMP));
            end
            8'h4C: begin
                q.push_back(rd(A_PC, A_PC, S_TMPL | S_INC));
                q.push_back(rd(A_PC, A_PC, S_PC));
            end
            default: begin
                q.push_back(rd(A_PC, A_PC, 8'h00));
                halt_pend = 1'b1;
            end
        endcase
    endtask

    // One clock: predict, check at negedge, advance model, drive next inputs.
    task automatic run_cycle(bit rst_next, bit rdy_rand);
        exp_t e;
        exp_t p;
        bit   stall = 1'b0;
        bit   load_ir = 1'b0;
        if (!Reset_n) begin
            e = rd(A_RST, A_R0, 8'h00);
        end else begin
            if (q.size() > 0) e = q[0];
            else begin
                e = rd(A_PC, A_PC, 8'h00);
                e.halt = 1'b1;
            end
            stall = e.r && !Rdy;
            if (stall) e.st = '0;
        end
        @(negedge Clk);
        check_eq("outputs", 32'(act), 32'(e));
        check_eq("adh_onehot", $countones(act.adh), 1);
        check_eq("adl_onehot", $countones(act.adl), 1);
        @(posedge Clk);
        if (!Reset_n) begin
            q.delete();
            q.push_back(rd(A_RST, A_R0, S_TMPL));
            q.push_back(rd(A_RST, A_R1, S_PC));
            halt_pend = 1'b0;
        end else if (!stall && q.size() > 0) begin
            p = q.pop_front();
            load_ir = p.sync;
        end
        if (Reset_n && q.size() == 0 && !halt_pend) refill();
        #1;
        if (load_ir) IR = pend_op;
        Reset_n = rst_next;
        if (stall_left > 0 && q.size() > 0 && q[0].adh == A_ZERO) begin
            Rdy = 1'b0;
            stall_left--;
        end else if (rdy_rand) begin
            Rdy = ($urandom_range(0, 3) != 0);
        end else begin
            Rdy = 1'b1;
        end
    endtask

    initial begin
        @(posedge Clk);
        #1;
        // Directed: reset, then a fixed program with a 5-cycle stall in ZP_MEM.
        for (int i = 0; i < 3; i++) run_cycle(i == 2, 1'b0);
        prog = '{8'hA9, 8'hA9, 8'h8D, 8'h4C, 8'hA5, 8'hA2, 8'hE8, 8'hEA, 8'h85, 8'hAD};
        stall_left = 5;
        for (int i = 0; i < 45; i++) run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) run_cycle($urandom_range(0, 99) != 0, 1'b1);
        // Directed: illegal opcode halts until a reset pulse.
        run_cycle(1'b0, 1'b0);
        prog = '{8'h02};
        run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 110; i++) run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
